// File: rtl/aes_pkg.sv
// AES-128 constants, S-box tables, GF(2^8) helpers and single-step key schedule words.
// 128-bit values are big-endian: byte 0 of the state is bits [127:120].
package aes_pkg;

    localparam int unsigned STATE_W = 128;
    localparam int unsigned NR      = 10;
    localparam int unsigned RND_W   = 4;

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_INV, S_DONE} fsm_e;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        case (x)
            8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5; 8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
            8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0; 8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
            8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc; 8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
            8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a; 8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
            8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0; 8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
            8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b; 8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
            8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85; 8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
            8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5; 8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
            8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17; 8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
            8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88; 8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
            8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c; 8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
            8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9; 8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
            8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6; 8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
            8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e; 8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
            8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94; 8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
            8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68; 8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        case (x)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38; 8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87; 8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d; 8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2; 8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16; 8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda; 8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a; 8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02; 8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea; 8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85; 8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89; 8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20; 8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31; 8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d; 8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0; 8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26; 8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] rnd);
        logic [7:0] r;
        r = 8'h00;
        case (rnd)
            4'd1: r = 8'h01; 4'd2: r = 8'h02; 4'd3: r = 8'h04; 4'd4: r = 8'h08; 4'd5: r = 8'h10;
            4'd6: r = 8'h20; 4'd7: r = 8'h40; 4'd8: r = 8'h80; 4'd9: r = 8'h1b; 4'd10: r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by the InvMixColumns coefficients 9, 11, 13 and 14 only.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] x2, x4, x8, r;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (c)
            8'd9:    r = x8 ^ a;
            8'd11:   r = x8 ^ x2 ^ a;
            8'd13:   r = x8 ^ x4 ^ a;
            8'd14:   r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [STATE_W-1:0] fwd_key(input logic [STATE_W-1:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h000000};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one schedule step: recover the later words first, then w0 from the recovered w3.
    function automatic logic [STATE_W-1:0] inv_key(input logic [STATE_W-1:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module inv_round
    import aes_pkg::*;
(
    input  logic [STATE_W-1:0] st_i,
    input  logic [STATE_W-1:0] rk_i,
    input  logic               last_i,
    output logic [STATE_W-1:0] st_nxt_c_o
);

    logic [7:0] in_b  [16];
    logic [7:0] sub_b [16];
    logic [7:0] out_b [16];

    always_comb begin
        st_nxt_c_o = '0;
        for (int i = 0; i < 16; i++) begin
            in_b[i] = st_i[8*(15-i) +: 8];
        end
        // Row r of column c comes from column c-r; byte index is 4*column + row.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_b[4*c+r] = inv_sbox(in_b[4*((c-r+4)%4)+r]) ^ rk_i[8*(15-(4*c+r)) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                out_b[4*c+r] = last_i ? sub_b[4*c+r]
                             : gmul(sub_b[4*c+r], 8'd14)         ^ gmul(sub_b[4*c+(r+1)%4], 8'd11)
                             ^ gmul(sub_b[4*c+(r+2)%4], 8'd13)   ^ gmul(sub_b[4*c+(r+3)%4], 8'd9);
            end
        end
        for (int i = 0; i < 16; i++) begin
            st_nxt_c_o[8*(15-i) +: 8] = out_b[i];
        end
    end

endmodule

// File: rtl/aes128_decrypt.sv
// Iterative AES-128 decryptor: forward key expansion to K10, then ten inverse rounds
// deriving each earlier round key on the fly. Byte 0 of every 128-bit bus is bits [127:120].
module aes128_decrypt
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] ciphertext,
    input  logic [STATE_W-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] plaintext
);

    fsm_e               fsm_q, fsm_d;
    logic [STATE_W-1:0] st_q, st_d;
    logic [STATE_W-1:0] rk_q, rk_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic [STATE_W-1:0] fwd_c, kp_c, inv_nxt_c;
    logic               last_c;

    assign last_c = (rnd_q == RND_W'(1));
    assign fwd_c  = fwd_key(rk_q, rcon(rnd_q));
    assign kp_c   = inv_key(rk_q, rcon(rnd_q));

    inv_round u_inv_round (
        .st_i       (st_q),
        .rk_i       (kp_c),
        .last_i     (last_c),
        .st_nxt_c_o (inv_nxt_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= S_IDLE;
            st_q  <= '0;
            rk_q  <= '0;
            rnd_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
            rk_q  <= rk_d;
            rnd_q <= rnd_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        rk_d  = rk_q;
        rnd_d = rnd_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d  = ciphertext;
                    rk_d  = key;
                    rnd_d = RND_W'(1);
                    fsm_d = S_EXPAND;
                end
            end
            S_EXPAND: begin
                rk_d = fwd_c;
                // Final expansion step doubles as the initial AddRoundKey with K10.
                if (rnd_q == RND_W'(NR)) begin
                    st_d  = st_q ^ fwd_c;
                    fsm_d = S_INV;
                end else begin
                    rnd_d = rnd_q + RND_W'(1);
                end
            end
            S_INV: begin
                st_d  = inv_nxt_c;
                rk_d  = kp_c;
                rnd_d = rnd_q - RND_W'(1);
                if (last_c) begin
                    fsm_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign plaintext = st_q;

endmodule

// File: tb/tb_aes128_decrypt.sv
// Directed bench for aes128_decrypt: known-answer vectors, back-to-back, backpressure,
// busy-input and mid-operation reset sequences.
module tb_aes128_decrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        logic [127:0] k10;
    } vec_t;

    vec_t vecs [4];

    aes128_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Called at a falling edge; waits a bounded number of cycles for out_valid.
    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 60) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_one(input vec_t v, input string tag);
        int lat;
        bit busy_ok;
        @(negedge clk);
        ciphertext = v.ct;
        key        = v.key;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        chk({tag, "_ready_before"}, 128'(in_ready), 128'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 60) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 10) chk({tag, "_rk_k10"}, dut.rk_q, v.k10);
        end
        chk({tag, "_latency"}, 128'(lat), 128'd20);
        chk({tag, "_pt"}, plaintext, v.pt);
        chk({tag, "_busy_ready_low"}, 128'(busy_ok), 128'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_drop"}, 128'(out_valid), 128'd0);
        chk({tag, "_ready_back"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, cyc, nacc, nout, idle_hi, both_hi;
        int acc_t [2];
        bit took, stable_ok;

        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt:  128'h00112233445566778899aabbccddeeff, k10: 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3925841d02dc09fbdc118597196a0b32,
                    pt:  128'h3243f6a8885a308d313198a2e0370734, k10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[2] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    pt:  128'h6bc1bee22e409f96e93d7e117393172a, k10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, ct: 128'hf5d3d58503b9699de785895a96fdbaaf,
                    pt:  128'hae2d8a571e03ac9c9eb76fac45af8e51, k10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ciphertext = '0;
        key        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_plaintext", plaintext, 128'd0);

        for (int i = 0; i < 4; i++) begin
            run_one(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back: in_valid and out_ready held high, second vector presented after first accept.
        nacc = 0; nout = 0; cyc = 0; idle_hi = 0; both_hi = 0;
        acc_t[0] = 0; acc_t[1] = 0;
        @(negedge clk);
        ciphertext = vecs[0].ct; key = vecs[0].key; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 120 && nout < 2; k++) begin
            took = 1'b0;
            if (in_ready && out_valid) both_hi++;
            if (in_ready) begin
                idle_hi++;
                if (in_valid && nacc < 2) begin
                    acc_t[nacc] = cyc + 1;
                    nacc++;
                    took = 1'b1;
                end
            end
            if (out_valid) begin
                chk($sformatf("b2b_pt%0d", nout), plaintext, vecs[nout].pt);
                nout++;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (took) begin
                if (nacc == 1) begin
                    ciphertext = vecs[1].ct; key = vecs[1].key;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("b2b_outputs", 128'(nout), 128'd2);
        chk("b2b_period", 128'(acc_t[1] - acc_t[0]), 128'd22);
        chk("b2b_idle_cycles", 128'(idle_hi), 128'd2);
        chk("b2b_ready_valid_excl", 128'(both_hi), 128'd0);

        // Backpressure: DONE holds for 15 cycles with a stable result.
        @(negedge clk);
        ciphertext = vecs[0].ct; key = vecs[0].key; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        chk("bp_valid", 128'(out_valid), 128'd1);
        stable_ok = 1'b1;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (plaintext !== vecs[0].pt || in_ready !== 1'b0 || out_valid !== 1'b1) stable_ok = 1'b0;
        end
        chk("bp_pt", plaintext, vecs[0].pt);
        chk("bp_stable", 128'(stable_ok), 128'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", 128'(out_valid), 128'd0);
        chk("bp_release_ready", 128'(in_ready), 128'd1);

        // Busy input: new vector pulsed during INV must be ignored.
        ciphertext = vecs[1].ct; key = vecs[1].key; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        ciphertext = vecs[0].ct; key = vecs[0].key; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        chk("busy_valid", 128'(out_valid), 128'd1);
        chk("busy_pt", plaintext, vecs[1].pt);
        @(posedge clk);
        @(negedge clk);

        // Reset during EXPAND.
        ciphertext = vecs[0].ct; key = vecs[0].key; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_exp_in_ready", 128'(in_ready), 128'd1);
        chk("rst_exp_out_valid", 128'(out_valid), 128'd0);
        chk("rst_exp_plaintext", plaintext, 128'd0);

        // Reset during INV, with a simultaneous in_valid that must lose to reset.
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_inv_in_ready", 128'(in_ready), 128'd1);
        chk("rst_inv_out_valid", 128'(out_valid), 128'd0);
        chk("rst_inv_plaintext", plaintext, 128'd0);

        run_one(vecs[0], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes128_decrypt.md
# aes128_decrypt

Iterative AES-128 decryption engine. It is the inverse counterpart of the encryption round datapath and sits on the same 128-bit big-endian state bus. It takes a ciphertext and the original cipher key through a valid/ready handshake. It expands the key forward to the final round key, then runs ten inverse rounds, one per clock, deriving each earlier round key on the fly. The plaintext is returned on a second valid/ready handshake.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10.
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  ciphertext and key present.
- `in_ready`  out  1  block can accept input; high only in IDLE.
- `ciphertext`  in  [0:127]  byte 0 = bits [0:7]; column-major state, as elsewhere in the design.
- `key`  in  [0:127]  original cipher key K0, same byte order.
- `out_valid`  out  1  plaintext available; high only in DONE.
- `out_ready`  in  1  consumer accepts plaintext.
- `plaintext`  out  [0:127]  driven directly from the state register.

## Operation
- Registers:
  - `st` (128): working state.
  - `rk` (128): current round key.
  - `rnd` (4): round counter.
  - `fsm`: IDLE, EXPAND, INV, DONE.
- IDLE: `in_ready`=1. On `in_valid`, `st`<=`ciphertext`, `rk`<=`key`, `rnd`<=1, go to EXPAND. While `in_valid`=0, remain in IDLE.
- EXPAND: each cycle, `rk`<=fwd(`rk`, Rcon[`rnd`]), then `rnd`++.
  - fwd computes w0'=w0^SubWord(RotWord(w3))^Rcon, then w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - When `rnd`==10, also do the initial AddRoundKey in that same cycle: `st`<=`st`^fwd(...). Then `rk`<=K10, `rnd`<=10, go to INV.
- INV: each cycle, Kp=inv(`rk`, Rcon[`rnd`]).
  - inv computes w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, then w0'=w0^SubWord(RotWord(w3'))^Rcon.
  - `st`<=InvMixColumns(InvSubBytes(InvShiftRows(`st`))^Kp).
  - When `rnd`==1, InvMixColumns is bypassed and Kp=K0.
  - `rk`<=Kp, `rnd`--. After the `rnd`==1 cycle, go to DONE.
- DONE: `out_valid`=1 and `plaintext`=`st`, held stable. On `out_ready`, go to IDLE.
- Input is ignored whenever `in_ready`=0. No queuing, no abort other than `rst`.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- All arithmetic is GF(2^8) with polynomial 0x11b. Nothing wider than 8 bits is ever added.

## Timing
- Reset, on the edge where `rst`=1: `fsm`=IDLE, `st`=0, `rk`=0, `rnd`=0. After that edge: `in_ready`=1, `out_valid`=0, `plaintext`=0.
- `rst` overrides every other input, including an in-progress decrypt and a simultaneous `in_valid`.
- Latency: with acceptance at edge E0, EXPAND occupies E1–E10 and INV occupies E11–E20. `out_valid` is high from just after E20.
- Output handshake completes at the first edge with `out_ready`=1 while in DONE; `out_valid` drops after that edge.
- IDLE lasts at least one cycle. With `out_ready` held at 1, accepts happen at E0, E22, E44, …, giving a period of 22 cycles.
- Backpressure: DONE holds indefinitely and `plaintext` must not change.
- `in_ready` and `out_valid` are pure decodes of `fsm` and never both high. The block has no combinational path from input to output.

## Structure
- Package `aes_pkg` holds:
  - `SBOX` and `INV_SBOX` functions, 256-entry case tables.
  - `rcon(rnd)`, `xtime`, and `gmul` for the constants 9, 11, 13, 14.
  - `fwd_key` and `inv_key` word functions.
  - Constants `STATE_W`=128 and `NR`=10.
- One combinational sub-module, `inv_round`: inputs `st`, `rk`, `last`; output the next state. It contains InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns, with InvMixColumns skipped when `last`=1.
- The FSM, counter, key register and handshakes live in the top level.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, `out_ready`=1 → pt 00112233445566778899aabbccddeeff, `out_valid` first high 20 edges after the accept edge. Internally, `rk` is 13111d7fe3944a17f307a78b4d2b30c5 on entry to INV.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734.
- Back-to-back blocks: `in_valid` and `out_ready` held at 1 with both vectors → two correct outputs, accepts 22 cycles apart, `in_ready` low throughout each busy interval.
- Backpressure: `out_ready`=0 for 15 cycles after `out_valid` → `plaintext` constant, `in_ready`=0; releasing `out_ready` completes the handshake in 1 cycle.
- Busy input: change `ciphertext`/`key` and pulse `in_valid` during INV → result still matches the originally accepted vector.
- Reset mid-op: assert `rst` for 1 cycle during EXPAND, and again during INV → next cycle `in_ready`=1, `out_valid`=0, `plaintext`=0. A fresh C.1 decrypt afterwards is correct with 20-edge latency.
